// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one i2c_master_v2 between NUM_REQ requesters.
// Round-robin grant, one 32-bit command per grant, completion or watchdog
// recovery, then an enforced bus-free gap before the next grant.
module i2c_txn_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 200000,
  parameter int GAP_CYCLES = 64,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*32-1:0] cmd,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic                 m_en,
  output logic [31:0]          m_cmd,
  input  logic                 m_done,
  input  logic [15:0]          m_data,
  input  logic                 m_err,
  output logic                 m_rst
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [23:0]   TMO_LAST  = 24'(TIMEOUT - 1);
  localparam logic [15:0]   GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_DONE    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  state_t               state_r;
  logic [IW-1:0]        last_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic [NUM_REQ-1:0]   done_r;
  logic [15:0]          rsp_data_r;
  logic                 rsp_err_r;
  logic                 rsp_timeout_r;
  logic                 busy_r;
  logic                 m_en_r;
  logic [31:0]          m_cmd_r;
  logic                 m_rst_r;
  logic [23:0]          timer_r;
  logic [15:0]          gap_r;
  logic [RW-1:0]        rcnt_r;

  logic [IW-1:0]        win_s;
  logic                 win_vld_s;
  logic [IW:0]          sum_s;
  logic [IW-1:0]        idx_s;
  logic [31:0]          cmd_sel_s;
  logic [NUM_REQ-1:0]   gnt_sel_s;

  // Round-robin pick: scan last+1, last+2, ... so the smallest offset wins.
  // Iterating from the largest offset down lets the nearest request overwrite.
  always_comb begin
    win_s     = '0;
    win_vld_s = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum_s     = {1'b0, last_r} + (IW+1)'(k);
      idx_s     = (sum_s >= (IW+1)'(NUM_REQ)) ? IW'(sum_s - (IW+1)'(NUM_REQ))
                                              : sum_s[IW-1:0];
      win_s     = req[idx_s] ? idx_s : win_s;
      win_vld_s = win_vld_s | req[idx_s];
    end
  end

  // Select the winner's command slice and build its one-hot grant.
  always_comb begin
    cmd_sel_s = 32'h0000_0000;
    gnt_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_sel_s    = (win_s == IW'(i)) ? cmd[32*i +: 32] : cmd_sel_s;
      gnt_sel_s[i] = (win_s == IW'(i));
    end
  end

  // Transaction FSM: grant, issue, wait/recover, report, then bus-free gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      last_r        <= LAST_INIT;
      gnt_r         <= '0;
      done_r        <= '0;
      rsp_data_r    <= 16'h0000;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
      m_en_r        <= 1'b0;
      m_cmd_r       <= 32'h0000_0000;
      m_rst_r       <= 1'b0;
      timer_r       <= 24'd0;
      gap_r         <= 16'd0;
      rcnt_r        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_vld_s) begin
            m_cmd_r <= cmd_sel_s;
            gnt_r   <= gnt_sel_s;
            last_r  <= win_s;
            m_en_r  <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          m_en_r  <= 1'b0;
          timer_r <= 24'd0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes precedence over a timeout firing on the same cycle.
          if (m_done) begin
            rsp_data_r    <= m_data;
            rsp_err_r     <= m_err;
            rsp_timeout_r <= 1'b0;
            done_r        <= gnt_r;
            state_r       <= ST_DONE;
          end else if (timer_r == TMO_LAST) begin
            m_rst_r <= 1'b1;
            rcnt_r  <= '0;
            state_r <= ST_RECOVER;
          end else begin
            timer_r <= timer_r + 24'd1;
          end
        end
        ST_RECOVER: begin
          if (rcnt_r == RST_LAST) begin
            m_rst_r       <= 1'b0;
            rsp_data_r    <= 16'h0000;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
            done_r        <= gnt_r;
            state_r       <= ST_DONE;
          end else begin
            rcnt_r <= rcnt_r + RW'(1);
          end
        end
        ST_DONE: begin
          done_r  <= '0;
          gnt_r   <= '0;
          gap_r   <= 16'd0;
          state_r <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_r == GAP_LAST) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= '0;
          done_r  <= '0;
          busy_r  <= 1'b0;
          m_en_r  <= 1'b0;
          m_rst_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_r;
  assign done        = done_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;
  assign busy        = busy_r;
  assign m_en        = m_en_r;
  assign m_cmd       = m_cmd_r;
  assign m_rst       = m_rst_r;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Testbench for i2c_txn_arbiter: directed transactions with a scoreboard of
// expected grants/commands and expected completion responses.
module tb_i2c_txn_arbiter;

  localparam int NR   = 4;
  localparam int TMO  = 50;
  localparam int GAP  = 16;
  localparam int RSTC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*32-1:0] cmd;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic [15:0]     rsp_data;
  logic            rsp_err;
  logic            rsp_timeout;
  logic            busy;
  logic            m_en;
  logic [31:0]     m_cmd;
  logic            m_done;
  logic [15:0]     m_data;
  logic            m_err;
  logic            m_rst;

  i2c_txn_arbiter #(
    .NUM_REQ(NR), .TIMEOUT(TMO), .GAP_CYCLES(GAP), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .gnt(gnt), .done(done),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .m_en(m_en), .m_cmd(m_cmd), .m_done(m_done),
    .m_data(m_data), .m_err(m_err), .m_rst(m_rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  d;
    logic [15:0] data;
    logic        err;
    logic        to;
  } rsp_t;

  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] c;
  } cmdx_t;

  rsp_t  exp_rsp[$];
  cmdx_t exp_cmd[$];
  int    n_total = 0;
  int    n_fail  = 0;
  int    rst_cycles = 0;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Response monitor: every done strobe must match the oldest queued response.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && done != 4'b0000) begin
      if (exp_rsp.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_rsp.pop_front();
        check("done_owner", 32'(done), 32'(e.d));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
  end

  // Command monitor: every m_en pulse must match the oldest queued grant.
  always @(negedge clk) begin
    cmdx_t e;
    if (!rst && m_en) begin
      if (exp_cmd.size() == 0) begin
        check("unexpected_men", 32'(m_en), 32'd0);
      end else begin
        e = exp_cmd.pop_front();
        check("gnt_owner", 32'(gnt), 32'(e.g));
        check("m_cmd", m_cmd, e.c);
      end
    end
    if (!rst && m_rst) rst_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_men(output int lat);
    lat = 0;
    while (m_en !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (m_en !== 1'b1) check("men_wait_bound", 32'(m_en), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_wait_bound", 32'(busy), 32'd0);
  endtask

  // Called on the negedge where m_en is seen; completes `delay` cycles after it.
  task automatic finish_txn(input int delay, input logic [15:0] data,
                            input logic err, input logic [3:0] who);
    exp_rsp.push_back('{d: who, data: data, err: err, to: 1'b0});
    tick(1);
    check("men_one_cycle", 32'(m_en), 32'd0);
    tick(delay - 1);
    m_done = 1'b1;
    m_data = data;
    m_err  = err;
    tick(1);
    m_done = 1'b0;
    m_data = 16'h0000;
    m_err  = 1'b0;
    check("done_latency", 32'(done), 32'(who));
  endtask

  task automatic post(input int i, input logic [31:0] c);
    cmd[32*i +: 32] = c;
    exp_cmd.push_back('{g: 4'(1 << i), c: c});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_m_en"}, 32'(m_en), 32'd0);
    check({tag, "_m_rst"}, 32'(m_rst), 32'd0);
    check({tag, "_m_cmd"}, m_cmd, 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
  endtask

  // Hard stop if the run ever stalls.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int w;
    int rst_before;
    rst = 1'b1; req = '0; cmd = '0;
    m_done = 1'b0; m_data = 16'h0000; m_err = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Single write from requester 0
    post(0, 32'h5010_ABCD);
    req = 4'b0001;
    wait_men(lat);
    check("men_latency", 32'(lat), 32'd1);
    finish_txn(30, 16'h0000, 1'b0, 4'b0001);
    req = 4'b0000;
    tick(1);
    check("gnt_release", 32'(gnt), 32'd0);
    tick(GAP - 1);
    check("busy_in_gap", 32'(busy), 32'd1);
    tick(1);
    check("busy_after_gap", 32'(busy), 32'd0);

    // Read with ACK error from requester 1
    post(1, 32'hD020_0000);
    req = 4'b0010;
    wait_men(lat);
    finish_txn(20, 16'h1234, 1'b1, 4'b0010);
    req = 4'b0000;
    wait_idle();

    // Contention from a fresh reset: order 0,1,2,3,0
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < NR; i++) cmd[32*i +: 32] = 32'hA000_0000 + 32'(i);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      post(t % NR, 32'hA000_0000 + 32'(t % NR));
      wait_men(lat);
      finish_txn(5 + t, 16'h1000 + 16'(t), 1'b0, 4'(1 << (t % NR)));
    end
    // From last=0 with requesters 0 and 2 pending, 2 wins
    req = 4'b0101;
    post(2, 32'hA000_0002);
    wait_men(lat);
    finish_txn(5, 16'h2222, 1'b0, 4'b0100);
    req = 4'b0000;
    wait_idle();

    // Timeout: master never completes
    post(3, 32'h8E3C_0000);
    req = 4'b1000;
    wait_men(lat);
    exp_rsp.push_back('{d: 4'b1000, data: 16'h0000, err: 1'b1, to: 1'b1});
    n = 0;
    while (m_rst !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    // m_rst rises TIMEOUT cycles after m_en falls
    check("m_rst_start", 32'(n), 32'(TMO + 1));
    w = 0;
    while (m_rst === 1'b1 && w < 50) begin
      tick(1);
      w++;
    end
    check("m_rst_width", 32'(w), 32'(RSTC));
    check("timeout_done", 32'(done), 32'b1000);
    req = 4'b0000;
    wait_idle();

    // m_done on the very cycle the timeout would fire
    rst_before = rst_cycles;
    post(0, 32'h3344_5566);
    req = 4'b0001;
    wait_men(lat);
    finish_txn(TMO, 16'hBEEF, 1'b0, 4'b0001);
    req = 4'b0000;
    wait_idle();
    check("coincident_no_m_rst", 32'(rst_cycles - rst_before), 32'd0);

    // Reset in the middle of WAIT, then a stale m_done
    post(1, 32'h1122_3344);
    req = 4'b0010;
    wait_men(lat);
    tick(10);
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check_reset_outputs("midwait");
    tick(2);
    rst = 1'b0;
    tick(2);
    m_done = 1'b1;
    m_data = 16'h5555;
    tick(1);
    m_done = 1'b0;
    m_data = 16'h0000;
    check("late_done_ignored", 32'(done), 32'd0);
    tick(5);
    check("late_busy", 32'(busy), 32'd0);

    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
